// File: rtl/matvec_ctrl.sv
// ----------------------------------------------------------------------------
// matvec_ctrl
//
// Control FSM for a KxK matrix-vector multiply datapath built from a matrix
// memory, a vector memory (both with 1-cycle registered read), a single MAC
// and an output register.
//
// A product starts with a first word whose new_matrix flag chooses between
// loading K*K matrix words followed by K vector words, or loading only the
// K vector words and reusing the stored matrix. Once the vector is loaded,
// the controller runs K row dot-products. Each product is K reads, one
// drain cycle, and then the row result is presented until it is accepted.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   input_valid/ready     input word handshake
//   new_matrix            sampled on the first word of a product only
//   output_valid/ready    row result handshake
//   wr_en_m, addr_m       matrix memory write strobe / address (wr and rd)
//   wr_en_v, addr_v       vector memory write strobe / address (wr and rd)
//   en_acc, acc_first     MAC accumulate enable / load-instead-of-add
// ----------------------------------------------------------------------------
module matvec_ctrl #(
    parameter int K      = 8,
    parameter int ADDR_M = $clog2(K*K),
    parameter int ADDR_V = $clog2(K)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              input_valid,
    output logic              input_ready,
    input  logic              new_matrix,
    output logic              output_valid,
    input  logic              output_ready,
    output logic              wr_en_m,
    output logic [ADDR_M-1:0] addr_m,
    output logic              wr_en_v,
    output logic [ADDR_V-1:0] addr_v,
    output logic              en_acc,
    output logic              acc_first
);

    typedef enum logic [2:0] {
        S_FIRST,
        S_LOAD_M,
        S_LOAD_V,
        S_COMPUTE,
        S_WAIT,
        S_OUT
    } state_t;

    localparam logic [ADDR_M-1:0] LP_M_LAST = ADDR_M'(K*K - 1);
    localparam logic [ADDR_M-1:0] LP_V_LAST = ADDR_M'(K - 1);
    localparam logic [ADDR_V-1:0] LP_RC_LAST = ADDR_V'(K - 1);

    state_t            r_state;
    logic [ADDR_M-1:0] r_cnt;
    logic [ADDR_V-1:0] r_row;
    logic [ADDR_V-1:0] r_col;
    logic              r_en_acc;
    logic              r_acc_first;

    logic              w_in_hs;
    logic [ADDR_M-1:0] w_rc_addr;

    assign w_in_hs   = input_valid && input_ready;
    // Row-major matrix read address for the current row/column.
    assign w_rc_addr = ADDR_M'(r_row) * ADDR_M'(K) + ADDR_M'(r_col);

    // Outputs are forced to zero while reset is high, so even the first
    // reset cycle (before the state register has returned to S_FIRST)
    // presents a quiet interface.
    always_comb begin
        input_ready  = 1'b0;
        output_valid = 1'b0;
        wr_en_m      = 1'b0;
        wr_en_v      = 1'b0;
        addr_m       = '0;
        addr_v       = '0;
        en_acc       = 1'b0;
        acc_first    = 1'b0;
        if (!reset) begin
            output_valid = (r_state == S_OUT);
            en_acc       = r_en_acc;
            acc_first    = r_acc_first;
            case (r_state)
                S_FIRST: begin
                    input_ready = 1'b1;
                    // new_matrix may be X when input_valid is low; the AND
                    // with input_valid keeps the strobes clean.
                    wr_en_m     = input_valid && new_matrix;
                    wr_en_v     = input_valid && !new_matrix;
                end
                S_LOAD_M: begin
                    input_ready = 1'b1;
                    wr_en_m     = input_valid;
                    addr_m      = r_cnt;
                    addr_v      = r_col;
                end
                S_LOAD_V: begin
                    input_ready = 1'b1;
                    wr_en_v     = input_valid;
                    addr_m      = w_rc_addr;
                    addr_v      = r_cnt[ADDR_V-1:0];
                end
                default: begin
                    // COMPUTE issues reads; WAIT/OUT keep the last read
                    // address stable because col stops at K-1.
                    addr_m = w_rc_addr;
                    addr_v = r_col;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FIRST;
            r_cnt       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_en_acc    <= 1'b0;
            r_acc_first <= 1'b0;
        end else begin
            // Read data arrives one cycle after the address, so the MAC
            // controls trail the COMPUTE reads by one cycle.
            r_en_acc    <= (r_state == S_COMPUTE);
            r_acc_first <= (r_state == S_COMPUTE) && (r_col == '0);
            case (r_state)
                S_FIRST: begin
                    if (w_in_hs) begin
                        r_cnt   <= ADDR_M'(1);
                        r_state <= new_matrix ? S_LOAD_M : S_LOAD_V;
                    end
                end
                S_LOAD_M: begin
                    if (w_in_hs) begin
                        if (r_cnt == LP_M_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_LOAD_V;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_LOAD_V: begin
                    if (w_in_hs) begin
                        if (r_cnt == LP_V_LAST) begin
                            r_cnt   <= '0;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_state <= S_COMPUTE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (r_col == LP_RC_LAST) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_WAIT: begin
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (output_ready) begin
                        if (r_row == LP_RC_LAST) begin
                            r_state <= S_FIRST;
                        end else begin
                            r_row   <= r_row + 1'b1;
                            r_col   <= '0;
                            r_state <= S_COMPUTE;
                        end
                    end
                end
                default: begin
                    r_state <= S_FIRST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_ctrl.sv
`timescale 1ns/1ps
module tb_matvec_ctrl;
    localparam int K  = 8;
    localparam int AM = $clog2(K*K);
    localparam int AV = $clog2(K);

    typedef logic [0:K-1][15:0] row_t;

    typedef struct {
        bit   nm;
        int   kind;
        row_t v;
        row_t y;
        bit   rnd;
        int   stall_row;
        int   exp_cyc;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          input_valid;
    logic          input_ready;
    logic          new_matrix;
    logic          output_valid;
    logic          output_ready;
    logic          wr_en_m;
    logic [AM-1:0] addr_m;
    logic          wr_en_v;
    logic [AV-1:0] addr_v;
    logic          en_acc;
    logic          acc_first;
    logic [15:0]   input_data;

    always #5 clk = ~clk;

    matvec_ctrl #(.K(K)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .new_matrix   (new_matrix),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .wr_en_m      (wr_en_m),
        .addr_m       (addr_m),
        .wr_en_v      (wr_en_v),
        .addr_v       (addr_v),
        .en_acc       (en_acc),
        .acc_first    (acc_first)
    );

    // Behavioural datapath driven by the controller's strobes.
    logic [15:0] mem_m [K*K];
    logic [15:0] mem_v [K];
    logic [15:0] rd_m, rd_v;
    logic [31:0] acc;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en_m === 1'b1) mem_m[addr_m] <= input_data;
        if (wr_en_v === 1'b1) mem_v[addr_v] <= input_data;
        rd_m <= mem_m[addr_m];
        rd_v <= mem_v[addr_v];
        if (en_acc === 1'b1)
            acc <= (acc_first === 1'b1) ? 32'(rd_m) * 32'(rd_v)
                                        : acc + 32'(rd_m) * 32'(rd_v);
    end

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl [8];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic row_t pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {16'(a0), 16'(a1), 16'(a2), 16'(a3), 16'(a4), 16'(a5), 16'(a6), 16'(a7)};
    endfunction

    // 0: identity, 1: all ones, 2: row r filled with r+1, 3: element = K*r+c
    function automatic int mat_word(input int kind, input int r, input int c);
        case (kind)
            0:       return (r == c) ? 1 : 0;
            1:       return 1;
            2:       return r + 1;
            default: return K*r + c;
        endcase
    endfunction

    task automatic set_vec(input int i, input bit nm, input int kind, input row_t v,
                           input row_t y, input bit rnd, input int stall_row, input int exp_cyc);
        tbl[i].nm        = nm;
        tbl[i].kind      = kind;
        tbl[i].v         = v;
        tbl[i].y         = y;
        tbl[i].rnd       = rnd;
        tbl[i].stall_row = stall_row;
        tbl[i].exp_cyc   = exp_cyc;
    endtask

    task automatic run_product(input string tag, input bit nm, input int kind, input row_t v,
                               input row_t y, input bit rnd, input int stall_row,
                               input int exp_cyc, output int first_c, output int last_c);
        int nwords = nm ? K*K + K : K;
        int moff   = nm ? K*K : 0;
        int widx = 0, oidx = 0, guard = 0;
        int strobe_err = 0, rdy_err = 0, lat_err = 0, stall_err = 0;
        int af_cnt = 0, stall_n = 0, evt_c = -1;
        bit ov_prev = 1'b0, chk_addr = 1'b0, hs_in;
        first_c = -1;
        last_c  = -1;
        while (oidx < K && guard < 3000) begin
            guard++;
            @(negedge clk);
            if (widx < nwords && (!rnd || $urandom_range(0, 1) == 1)) begin
                input_valid = 1'b1;
                if (widx < moff) input_data = 16'(mat_word(kind, widx / K, widx % K));
                else             input_data = v[widx - moff];
                if (widx == 0)   new_matrix = nm;
                else             new_matrix = rnd ? 1'($urandom_range(0, 1)) : !nm;
            end else begin
                input_valid = 1'b0;
                input_data  = 'x;
                new_matrix  = 1'bx;
            end
            output_ready = !(oidx == stall_row && stall_n < 20);
            #1;
            hs_in = (input_valid === 1'b1) && (input_ready === 1'b1);
            if (input_ready !== (widx < nwords)) rdy_err++;
            if (hs_in) begin
                if (widx == 0) first_c = cyc;
                if (widx < moff) begin
                    if (wr_en_m !== 1'b1 || wr_en_v !== 1'b0 || addr_m !== AM'(widx)) strobe_err++;
                end else begin
                    if (wr_en_v !== 1'b1 || wr_en_m !== 1'b0 || addr_v !== AV'(widx - moff)) strobe_err++;
                end
                if (widx == nwords - 1) evt_c = cyc;
                widx++;
            end else if (wr_en_m !== 1'b0 || wr_en_v !== 1'b0) begin
                strobe_err++;
            end
            if (chk_addr) begin
                if (addr_m !== AM'(oidx*K) || addr_v !== AV'(0)) lat_err++;
                chk_addr = 1'b0;
            end
            if (acc_first === 1'b1) af_cnt++;
            if (output_valid === 1'b1 && !ov_prev) begin
                if (evt_c < 0 || cyc != evt_c + K + 2) lat_err++;
            end
            ov_prev = (output_valid === 1'b1);
            if (output_valid === 1'b1) begin
                if (output_ready) begin
                    check($sformatf("%s row%0d result", tag, oidx), acc, y[oidx]);
                    evt_c    = cyc;
                    last_c   = cyc;
                    oidx++;
                    chk_addr = (oidx < K);
                end else begin
                    stall_n++;
                    if (en_acc !== 1'b0 || addr_m !== AM'(oidx*K + K - 1) || acc !== 32'(y[oidx]))
                        stall_err++;
                end
            end
        end
        if (oidx < K) check({tag, " rows done before timeout"}, oidx, K);
        check({tag, " write strobe errors"}, strobe_err, 0);
        check({tag, " input_ready errors"}, rdy_err, 0);
        check({tag, " latency errors"}, lat_err, 0);
        check({tag, " acc_first pulses"}, af_cnt, K);
        if (stall_row >= 0) begin
            check({tag, " stall hold errors"}, stall_err, 0);
            check({tag, " stall cycles"}, stall_n, 20);
        end
        if (exp_cyc > 0) check({tag, " product cycles"}, last_c - first_c + 1, exp_cyc);
    endtask

    initial begin
        int fc, lc, t0, t1;
        row_t bv, by;

        set_vec(0, 1'b1, 0, pk(1,2,3,4,5,6,7,8),        pk(1,2,3,4,5,6,7,8),         1'b0, -1, 152);
        set_vec(1, 1'b0, 0, pk(10,20,30,40,50,60,70,80), pk(10,20,30,40,50,60,70,80), 1'b0, -1, 88);
        set_vec(2, 1'b1, 1, pk(1,2,3,4,5,6,7,8),        pk(36,36,36,36,36,36,36,36), 1'b0, -1, 152);
        set_vec(3, 1'b0, 1, pk(3,3,3,3,3,3,3,3),        pk(24,24,24,24,24,24,24,24), 1'b1, -1, 0);
        set_vec(4, 1'b1, 2, pk(1,1,1,1,1,1,1,1),        pk(8,16,24,32,40,48,56,64),  1'b0, -1, 152);
        set_vec(5, 1'b0, 2, pk(1,2,3,4,5,6,7,8),        pk(36,72,108,144,180,216,252,288), 1'b0, 3, 108);
        set_vec(6, 1'b1, 3, pk(1,0,0,0,0,0,0,0),        pk(0,8,16,24,32,40,48,56),   1'b1, -1, 0);
        set_vec(7, 1'b0, 3, pk(0,0,0,0,0,0,0,1),        pk(7,15,23,31,39,47,55,63),  1'b0, -1, 88);

        reset        = 1'b1;
        input_valid  = 1'b0;
        new_matrix   = 1'b0;
        output_ready = 1'b1;
        input_data   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset outputs", {input_ready, output_valid, wr_en_m, wr_en_v, en_acc, acc_first, addr_m, addr_v}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("input_ready after reset", input_ready, 1);

        // Abort a matrix load at cnt = 30 with a 2-cycle reset.
        input_valid = 1'b1;
        new_matrix  = 1'b1;
        input_data  = 16'h1111;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            new_matrix = 1'b0;
        end
        #1;
        check("load addr before reset", addr_m, 30);
        new_matrix = 1'b1;
        reset      = 1'b1;
        #1;
        check("reset cycle1 outputs", {input_ready, output_valid, wr_en_m, wr_en_v, en_acc, acc_first, addr_m, addr_v}, 0);
        @(negedge clk);
        #1;
        check("reset cycle2 outputs", {input_ready, output_valid, wr_en_m, wr_en_v, en_acc, acc_first, addr_m, addr_v}, 0);
        @(negedge clk);
        reset       = 1'b0;
        input_valid = 1'b0;
        #1;
        check("input_ready after mid reset", input_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_product($sformatf("vec%0d", i), tbl[i].nm, tbl[i].kind, tbl[i].v, tbl[i].y,
                        tbl[i].rnd, tbl[i].stall_row, tbl[i].exp_cyc, fc, lc);
        end

        // 100 back-to-back products, matrix reloaded every 4th.
        t0 = 0;
        t1 = 0;
        for (int p = 0; p < 100; p++) begin
            for (int r = 0; r < K; r++) begin
                bv[r] = (r == p % K) ? 16'(p + 1) : 16'd0;
                by[r] = 16'((p + 1) * (K*r + p % K));
            end
            run_product($sformatf("bulk%0d", p), (p % 4 == 0), 3, bv, by, 1'b0, -1,
                        (p % 4 == 0) ? 152 : 88, fc, lc);
            if (p == 0)  t0 = fc;
            if (p == 99) t1 = lc;
        end
        check("bulk total cycles", t1 - t0 + 1, 10400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/matvec_ctrl.md
Name: matvec_ctrl

Overview:
Control FSM for the KxK matrix-vector multiply datapath (matrix memory, vector memory, single MAC, output register). Accepts the streamed input (optional KxK matrix, then K-element vector) over a valid/ready handshake and generates the memory write strobes and addresses. Sequences K row dot-products through the MAC and presents each row result over a valid/ready output handshake. Purely control: data words flow directly from input_data into the memories, and from the accumulator to output_data.

Parameters:
K, 8, matrix dimension and vector length
ADDR_M, $clog2(K*K), matrix memory address width
ADDR_V, $clog2(K), vector memory address width

Ports:
clk  in  1  clock
reset  in  1  synchronous reset
input_valid  in  1  input word valid
input_ready  out  1  controller accepts an input word
new_matrix  in  1  sampled only on the first word of a product; 1 = a matrix precedes the vector
output_valid  out  1  accumulator holds a finished row result
output_ready  in  1  downstream accepts the result
wr_en_m  out  1  matrix memory write enable
addr_m  out  ADDR_M  matrix memory address (write and read)
wr_en_v  out  1  vector memory write enable
addr_v  out  ADDR_V  vector memory address (write and read)
en_acc  out  1  MAC accumulate enable
acc_first  out  1  with en_acc: acc <= product (discard old value)

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high.
- States: FIRST, LOAD_M, LOAD_V, COMPUTE, WAIT, OUT. Counters: cnt (load index), row, col.
- Handshake: an input word is accepted when input_valid && input_ready on a rising edge.
- input_ready = 1 only in FIRST, LOAD_M and LOAD_V. It is 0 in all other states and while reset is high.
- input_data and new_matrix may be X whenever input_valid = 0. The controller ignores them.
- new_matrix is ignored on every word other than the first word of a product.
- wr_en_m / wr_en_v are combinational: handshake && (this word targets that memory).
- FIRST, accepted word with new_matrix = 1: wr_en_m = 1, addr_m = 0, cnt <= 1, go to LOAD_M.
- FIRST, accepted word with new_matrix = 0: wr_en_v = 1, addr_v = 0, cnt <= 1, go to LOAD_V. The previously stored matrix is reused.
- LOAD_M: addr_m = cnt. cnt increments on each handshake. On the handshake at cnt = K*K-1: cnt <= 0, go to LOAD_V.
- LOAD_V: addr_v = cnt. On the handshake at cnt = K-1: row <= 0, col <= 0, go to COMPUTE.
- COMPUTE: one read per cycle, addr_m = row*K + col, addr_v = col, col increments. At col = K-1: go to WAIT.
- Memories have 1-cycle read latency. Therefore en_acc is registered (COMPUTE) delayed one cycle, and acc_first is registered (COMPUTE && col == 0) delayed one cycle.
- WAIT: lasts exactly 1 cycle. The last product is accumulated here (en_acc = 1). Then go to OUT.
- OUT: output_valid = 1 and is held until output_ready. While held, en_acc = 0 and no reads are issued.
- OUT, on output handshake with row = K-1: go to FIRST.
- OUT, on output handshake with row < K-1: row++, col <= 0, go to COMPUTE.
- Latency: last vector handshake at cycle T gives output_valid at T+K+2. Output handshake at cycle U gives the next output_valid at U+K+2.
- Throughput with no stalls, K = 8: 152 cycles per product with a matrix; 88 cycles per product without.
- Reset, including mid-operation: state <= FIRST. cnt, row, col, en_acc, acc_first <= 0. output_valid = 0, wr_en_m = 0, wr_en_v = 0, addr_m = 0, addr_v = 0.
- input_ready is 1 in the first cycle after reset deasserts. Memory contents are not cleared.
- A product with new_matrix = 0 issued after reset uses undefined matrix contents. This is legal and not flagged.
- No output is X after reset. Addresses are always driven from the counters.

Test Plan:
1. Reset: assert reset for 2 cycles at cnt = 30 of LOAD_M -> all outputs 0 during reset. input_ready = 1 on the next cycle, and the next word's new_matrix is sampled as a first word.
2. K = 8, new_matrix = 1, back-to-back valid -> wr_en_m for 64 consecutive cycles (addr_m 0..63), then wr_en_v for 8 cycles (addr_v 0..7). input_ready = 0 from the next cycle. output_valid rises 10 cycles after the last vector handshake.
3. First word new_matrix = 0 -> no wr_en_m pulses, 8 vector writes. COMPUTE addr_m sweeps 0..63 across the 8 rows. acc_first is high exactly once per row, 1 cycle after the col = 0 read.
4. output_ready held low for 20 cycles at row 3 -> output_valid stays 1, en_acc = 0, addr_m stays at 31. On release: row 4 reads start the next cycle, output_valid at +10.
5. Random input_valid with X data, plus new_matrix toggled on non-first words -> write strobes fire only on handshakes, cnt never skips or repeats, and the sequence is unaffected by new_matrix mid-product.
6. 100 products, new_matrix = 1 on every 4th, valid/ready always 1 -> 800 correct outputs in order. Totals 25*152 + 75*88 = 10400 cycles.
